// File: rtl/addsub_pkg.sv
// Shared types for the multi-cycle adder/subtractor: op encoding, flag layout
// and FSM states.
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Field order gives out_flags = {N,Z,C,V}.
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/addsub_multicycle_if.sv
// Request/response bundle of the multi-cycle adder/subtractor.
// Handshake: a transfer happens on the rising edge where valid and ready are both 1;
// valid, once raised, is held with stable payload until that edge.
interface addsub_multicycle_if
   import addsub_pkg::*;
#(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic             in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   flags_t           out_flags;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry entering the top
// bit so the caller can form the overflow flag.
module addsub_chunk #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);
   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end

   assign cout  = c[CHUNK];
   assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used by the ripple chains.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/addsub_multicycle.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per RUN cycle, carry kept in a
// register between slices, NZCV flags registered together with the last slice.
module addsub_multicycle
   import addsub_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic   clk,
   input  logic   reset_n,
   addsub_multicycle_if.slave bus,
   output state_e state_o
);
   localparam int          NCHUNK  = WIDTH / CHUNK;
   localparam int          CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned CHUNK_U = CHUNK;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_d;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   flags_t           flags_q;
   flags_t           flags_d;

   logic [CHUNK-1:0] a_slice;
   logic [CHUNK-1:0] b_slice;
   logic [CHUNK-1:0] sum;
   logic             cout;
   logic             c_msb;
   logic             last;
   int unsigned      base;

   assign base    = 32'(cnt_q) * CHUNK_U;
   assign last    = (cnt_q == CNT_W'(NCHUNK - 1));
   assign a_slice = a_q[base +: CHUNK];
   assign b_slice = b_q[base +: CHUNK];

   addsub_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a     (a_slice),
      .b     (b_slice),
      .cin   (carry_q),
      .sum   (sum),
      .cout  (cout),
      .c_msb (c_msb)
   );

   // On the last slice result_d is the complete word, so Z can be taken over it.
   always_comb begin
      result_d = result_q;
      result_d[base +: CHUNK] = sum;
      flags_d.n = result_d[WIDTH-1];
      flags_d.z = (result_d == '0);
      flags_d.c = cout;
      flags_d.v = c_msb ^ cout;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         flags_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q     <= bus.in_a;
                  b_q     <= (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
                  carry_q <= bus.in_op;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               result_q <= result_d;
               carry_q  <= cout;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (last) begin
                  flags_q <= flags_d;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.out_result = result_q;
   assign bus.out_flags  = flags_q;
   assign state_o        = state_q;
endmodule

// File: tb/tb_addsub_multicycle.sv
// Bench for addsub_multicycle: directed cases, backpressure, mid-run reset and a
// randomized sweep over four WIDTH/CHUNK configurations against an arithmetic model.
module tb_addsub_multicycle;
   import addsub_pkg::*;

   logic clk;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   addsub_multicycle_if #(.WIDTH(64)) if0 ();
   addsub_multicycle_if #(.WIDTH(64)) if1 ();
   addsub_multicycle_if #(.WIDTH(64)) if2 ();
   addsub_multicycle_if #(.WIDTH(8))  if3 ();
   state_e st0, st1, st2, st3;

   addsub_multicycle #(.WIDTH(64), .CHUNK(16)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0), .state_o(st0));
   addsub_multicycle #(.WIDTH(64), .CHUNK(64)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1), .state_o(st1));
   addsub_multicycle #(.WIDTH(64), .CHUNK(1))  dut2 (.clk(clk), .reset_n(reset_n), .bus(if2), .state_o(st2));
   addsub_multicycle #(.WIDTH(8),  .CHUNK(4))  dut3 (.clk(clk), .reset_n(reset_n), .bus(if3), .state_o(st3));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900us;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // Returns {N,Z,C,V,result} from plain modular arithmetic; C is "no borrow" on SUB.
   function automatic logic [67:0] ref_model(input int w, input logic op,
                                             input logic [63:0] a_in, input logic [63:0] b_in);
      logic [63:0] mask, a, b, r;
      logic [64:0] full;
      logic n, z, c, v, sa, sb, sr;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      a = a_in & mask;
      b = b_in & mask;
      if (op == OP_ADD) begin
         full = {1'b0, a} + {1'b0, b};
         r    = full[63:0] & mask;
         c    = full[w];
      end else begin
         r = (a - b) & mask;
         c = (a >= b);
      end
      sa = a[w-1];
      sb = b[w-1];
      sr = r[w-1];
      n  = sr;
      z  = (r == 64'd0);
      v  = (op == OP_ADD) ? ((sa == sb) && (sr != sa)) : ((sa != sb) && (sr != sa));
      return {n, z, c, v, r};
   endfunction

   // ---------------- drivers ----------------
   task automatic drv(input int cfg, input logic v, input logic op,
                      input logic [63:0] a, input logic [63:0] b, input logic ordy);
      case (cfg)
         0: begin if0.in_valid = v; if0.in_op = op; if0.in_a = a; if0.in_b = b; if0.out_ready = ordy; end
         1: begin if1.in_valid = v; if1.in_op = op; if1.in_a = a; if1.in_b = b; if1.out_ready = ordy; end
         2: begin if2.in_valid = v; if2.in_op = op; if2.in_a = a; if2.in_b = b; if2.out_ready = ordy; end
         3: begin if3.in_valid = v; if3.in_op = op; if3.in_a = a[7:0]; if3.in_b = b[7:0]; if3.out_ready = ordy; end
         default: ;
      endcase
   endtask

   task automatic smp(input int cfg, output logic rdy, output logic ov,
                      output logic [63:0] res, output logic [3:0] fl);
      rdy = 1'b0; ov = 1'b0; res = '0; fl = '0;
      case (cfg)
         0: begin rdy = if0.in_ready; ov = if0.out_valid; res = if0.out_result; fl = if0.out_flags; end
         1: begin rdy = if1.in_ready; ov = if1.out_valid; res = if1.out_result; fl = if1.out_flags; end
         2: begin rdy = if2.in_ready; ov = if2.out_valid; res = if2.out_result; fl = if2.out_flags; end
         3: begin rdy = if3.in_ready; ov = if3.out_valid; res = {56'd0, if3.out_result}; fl = if3.out_flags; end
         default: ;
      endcase
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // Issue one op, scramble the inputs while it runs, count edges to out_valid,
   // hold DONE for 'hold' cycles, then complete the output handshake.
   task automatic run_op(input int cfg, input logic op, input logic [63:0] a, input logic [63:0] b,
                         input int hold, output logic [63:0] res, output logic [3:0] fl, output int lat);
      logic rdy, ov;
      int n;
      drv(cfg, 1'b1, op, a, b, 1'b0);
      n = 0;
      smp(cfg, rdy, ov, res, fl);
      while (!rdy && n < 300) begin
         step();
         n++;
         smp(cfg, rdy, ov, res, fl);
      end
      step();
      drv(cfg, 1'b0, 1'($urandom_range(0, 1)), rnd64(), rnd64(), 1'b0);
      lat = 0;
      smp(cfg, rdy, ov, res, fl);
      while (!ov && lat < 300) begin
         step();
         lat++;
         smp(cfg, rdy, ov, res, fl);
      end
      repeat (hold) step();
      drv(cfg, 1'b0, 1'b0, rnd64(), rnd64(), 1'b1);
      step();
      drv(cfg, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++; if (if0.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", if0.in_ready); end
      checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", if0.out_valid); end
      checks++; if (if0.out_result !== 64'd0) begin errors++; $display("FAIL reset_out_result: got %h want 0", if0.out_result); end
      checks++; if (if0.out_flags !== 4'd0) begin errors++; $display("FAIL reset_out_flags: got %b want 0000", if0.out_flags); end
      checks++; if (st0 !== IDLE)           begin errors++; $display("FAIL reset_state: got %0d want IDLE", st0); end
   endtask

   task automatic test_directed();
      logic        ops [5] = '{OP_ADD, OP_SUB, OP_SUB, OP_ADD, OP_ADD};
      logic [63:0] as  [5] = '{64'd1, 64'd5, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      logic [63:0] bs  [5] = '{64'd2, 64'd5, 64'd1, 64'd1, 64'd1};
      logic [63:0] rs  [5] = '{64'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0};
      logic [3:0]  fs  [5] = '{4'b0000, 4'b0110, 4'b1000, 4'b1001, 4'b0110};
      logic [63:0] res;
      logic [3:0]  fl;
      int lat;
      for (int i = 0; i < 5; i++) begin
         run_op(0, ops[i], as[i], bs[i], 0, res, fl, lat);
         checks++; if (res !== rs[i]) begin errors++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, rs[i]); end
         checks++; if (fl !== fs[i])  begin errors++; $display("FAIL directed_flags[%0d]: got %b want %b", i, fl, fs[i]); end
         checks++; if (lat !== 4)     begin errors++; $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat); end
      end
   endtask

   task automatic test_backpressure();
      logic        op1, op2, rdy, ov;
      logic [63:0] a1, b1, a2, b2, res;
      logic [3:0]  fl;
      logic [67:0] e1, e2;
      int lat;
      op1 = OP_SUB; a1 = rnd64(); b1 = rnd64();
      op2 = OP_ADD; a2 = rnd64(); b2 = rnd64();
      e1 = ref_model(64, op1, a1, b1);
      e2 = ref_model(64, op2, a2, b2);
      drv(0, 1'b1, op1, a1, b1, 1'b0);
      step();
      drv(0, 1'b1, op2, a2, b2, 1'b0);
      lat = 0;
      smp(0, rdy, ov, res, fl);
      while (!ov && lat < 300) begin step(); lat++; smp(0, rdy, ov, res, fl); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", lat); end
      for (int k = 0; k < 10; k++) begin
         smp(0, rdy, ov, res, fl);
         checks++; if (res !== e1[63:0])   begin errors++; $display("FAIL bp_hold_result[%0d]: got %h want %h", k, res, e1[63:0]); end
         checks++; if (fl !== e1[67:64])   begin errors++; $display("FAIL bp_hold_flags[%0d]: got %b want %b", k, fl, e1[67:64]); end
         checks++; if (rdy !== 1'b0 || ov !== 1'b1) begin errors++; $display("FAIL bp_hold_hs[%0d]: got rdy=%b ov=%b want rdy=0 ov=1", k, rdy, ov); end
         step();
      end
      drv(0, 1'b1, op2, a2, b2, 1'b1);
      step();
      drv(0, 1'b1, op2, a2, b2, 1'b0);
      smp(0, rdy, ov, res, fl);
      checks++; if (rdy !== 1'b1 || ov !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b ov=%b want rdy=1 ov=0", rdy, ov); end
      step();
      drv(0, 1'b0, 1'b1, rnd64(), rnd64(), 1'b0);
      smp(0, rdy, ov, res, fl);
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bp_accept2: got in_ready=%b want 0", rdy); end
      lat = 0;
      while (!ov && lat < 300) begin step(); lat++; smp(0, rdy, ov, res, fl); end
      checks++; if (res !== e2[63:0]) begin errors++; $display("FAIL bp_second_result: got %h want %h", res, e2[63:0]); end
      checks++; if (fl !== e2[67:64]) begin errors++; $display("FAIL bp_second_flags: got %b want %b", fl, e2[67:64]); end
      drv(0, 1'b0, 1'b0, '0, '0, 1'b1);
      step();
      drv(0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic test_reset_mid_run();
      logic [63:0] res;
      logic [3:0]  fl;
      int lat;
      drv(0, 1'b1, OP_ADD, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
      step();
      drv(0, 1'b0, 1'b0, '0, '0, 1'b0);
      step();
      reset_n = 1'b0;
      #1;
      checks++; if (if0.out_valid !== 1'b0)   begin errors++; $display("FAIL midrst_out_valid: got %b want 0", if0.out_valid); end
      checks++; if (if0.in_ready !== 1'b1)    begin errors++; $display("FAIL midrst_in_ready: got %b want 1", if0.in_ready); end
      checks++; if (if0.out_result !== 64'd0) begin errors++; $display("FAIL midrst_out_result: got %h want 0", if0.out_result); end
      checks++; if (if0.out_flags !== 4'd0)   begin errors++; $display("FAIL midrst_out_flags: got %b want 0000", if0.out_flags); end
      @(negedge clk);
      reset_n = 1'b1;
      step();
      run_op(0, OP_SUB, 64'h10, 64'h20, 0, res, fl, lat);
      checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF0) begin errors++; $display("FAIL midrst_sub_result: got %h want fffffffffffffff0", res); end
      checks++; if (fl !== 4'b1000) begin errors++; $display("FAIL midrst_sub_flags: got %b want 1000", fl); end
   endtask

   task automatic test_sweep(input int cfg, input int w, input int nchunk, input int nops);
      logic [63:0] mask, a, b, res;
      logic [63:0] corner [5];
      logic [3:0]  fl;
      logic [67:0] e;
      logic        op;
      int lat;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      corner[0] = 64'd0;
      corner[1] = 64'd1;
      corner[2] = 64'd1 << (w - 1);
      corner[3] = mask >> 1;
      corner[4] = mask;
      for (int i = 0; i < nops; i++) begin
         if (i < 25) begin
            a = corner[i / 5];
            b = corner[i % 5];
         end else begin
            a = rnd64() & mask;
            b = rnd64() & mask;
         end
         op = 1'($urandom_range(0, 1));
         e  = ref_model(w, op, a, b);
         run_op(cfg, op, a, b, $urandom_range(0, 2), res, fl, lat);
         checks++; if (res !== e[63:0])  begin errors++; $display("FAIL sweep%0d_result[%0d]: op=%b a=%h b=%h got %h want %h", cfg, i, op, a, b, res, e[63:0]); end
         checks++; if (fl !== e[67:64])  begin errors++; $display("FAIL sweep%0d_flags[%0d]: op=%b a=%h b=%h got %b want %b", cfg, i, op, a, b, fl, e[67:64]); end
         checks++; if (lat !== nchunk)   begin errors++; $display("FAIL sweep%0d_latency[%0d]: got %0d want %0d", cfg, i, lat, nchunk); end
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      reset_n = 1'b0;
      for (int c = 0; c < 4; c++) drv(c, 1'b0, 1'b0, '0, '0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      reset_n = 1'b1;
      step();
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_sweep(0, 64, 4, 200);
      test_sweep(1, 64, 1, 1000);
      test_sweep(2, 64, 64, 300);
      test_sweep(3, 8, 2, 1000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
